// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC pipeline stage registers.
//   NOP_INST        : bubble encoding (addi x0,x0,0)
//   *_LSB           : instruction field bit positions
//   if_de_payload_t : instruction/PC pair carried from fetch to decode
package riscv_pipe_pkg;

    localparam int PIPE_XLEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] inst;
        logic [PIPE_XLEN-1:0] pc;
    } if_de_payload_t;

endpackage

// File: rtl/inst_field_split.sv
// Combinational decode of the fixed RISC instruction fields.
//   inst   : instruction (fields taken from bits [31:0])
//   rs1/rs2/rd/opcode/funct3/funct7 : extracted fields
module inst_field_split
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [XLEN-1:0]   inst,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7
);

    assign rs1    = inst[RS1_LSB +: REG_AW];
    assign rs2    = inst[RS2_LSB +: REG_AW];
    assign rd     = inst[RD_LSB +: REG_AW];
    assign opcode = inst[OPCODE_LSB +: 7];
    assign funct3 = inst[FUNCT3_LSB +: 3];
    assign funct7 = inst[FUNCT7_LSB +: 7];

    // Bits above 31 carry no fields on a wider datapath.
    generate
        if (XLEN > 32) begin : g_wide
            logic unused_hi;
            assign unused_hi = ^inst[XLEN-1:32];
        end
    endgenerate

endmodule

// File: rtl/if_de_pipe_reg.sv
// Elastic IF->DE pipeline register: valid/ready handshake, one-entry skid
// buffer, stall back-pressure and synchronous flush. Register fields are
// pre-extracted and registered alongside the instruction.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : kill held and incoming instructions
//   in_valid/in_ready : fetch handshake; in_inst/in_pc payload
//   out_valid/out_ready : decode handshake; out_* held payload and fields
module if_de_pipe_reg #(
    parameter int              XLEN     = 32,
    parameter int              REG_AW   = 5,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(riscv_pipe_pkg::NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7
);

    logic            main_valid, skid_valid;
    logic [XLEN-1:0] skid_inst, skid_pc;

    logic            main_valid_d, skid_valid_d;
    logic [XLEN-1:0] main_inst_d, main_pc_d, skid_inst_d, skid_pc_d;
    logic            in_fire, out_fire, load_main;

    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    logic [6:0]        opcode_d, funct7_d;
    logic [2:0]        funct3_d;

    // in_ready depends only on the skid register (and reset), so decode
    // back-pressure never reaches fetch combinationally.
    assign in_ready  = !skid_valid && !rst;
    assign out_valid = main_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;
    assign load_main = !main_valid || out_fire;

    always_comb begin
        main_valid_d = main_valid;
        main_inst_d  = out_inst;
        main_pc_d    = out_pc;
        skid_valid_d = skid_valid;
        skid_inst_d  = skid_inst;
        skid_pc_d    = skid_pc;
        if (rst || flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_inst_d  = NOP_INST;
            main_pc_d    = '0;
        end else if (load_main) begin
            if (skid_valid) begin
                // Skid is older than anything arriving now; it goes first.
                main_valid_d = 1'b1;
                main_inst_d  = skid_inst;
                main_pc_d    = skid_pc;
                skid_valid_d = in_fire;
                skid_inst_d  = in_inst;
                skid_pc_d    = in_pc;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_inst_d  = in_inst;
                main_pc_d    = in_pc;
            end else begin
                main_valid_d = 1'b0;
                main_inst_d  = NOP_INST;
                main_pc_d    = '0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = in_inst;
            skid_pc_d    = in_pc;
        end
    end

    // Fields are decoded from the next main instruction so they are
    // registered in the same edge as out_inst and can never disagree.
    inst_field_split #(.XLEN(XLEN), .REG_AW(REG_AW)) u_split (
        .inst   (main_inst_d),
        .rs1    (rs1_d),
        .rs2    (rs2_d),
        .rd     (rd_d),
        .opcode (opcode_d),
        .funct3 (funct3_d),
        .funct7 (funct7_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
        end
        // Payload next-state already forces the bubble under rst/flush.
        out_inst   <= main_inst_d;
        out_pc     <= main_pc_d;
        out_rs1    <= rs1_d;
        out_rs2    <= rs2_d;
        out_rd     <= rd_d;
        out_opcode <= opcode_d;
        out_funct3 <= funct3_d;
        out_funct7 <= funct7_d;
        skid_inst  <= skid_inst_d;
        skid_pc    <= skid_pc_d;
    end

endmodule

// File: tb/tb_if_de_pipe_reg.sv
module tb_if_de_pipe_reg;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_de_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7)
    );

    typedef struct {
        logic           rst, flush, in_valid, out_ready;
        if_de_payload_t in_p;
        logic           exp_ov, exp_ir;
        if_de_payload_t exp_p;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [31:0] ii, input logic [31:0] ip,
                                input logic orr, input logic eov, input logic eir,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = orr;
        v.in_p.inst = ii; v.in_p.pc = ip;
        v.exp_ov = eov; v.exp_ir = eir;
        v.exp_p.inst = ei; v.exp_p.pc = ep;
        return v;
    endfunction

    // {rs1, rs2, rd, opcode, funct3, funct7} of a RISC instruction
    function automatic logic [31:0] fields(input logic [31:0] e);
        return {e[19:15], e[24:20], e[11:7], e[6:0], e[14:12], e[31:25]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I1 = 32'h0050_0093, I2 = 32'h00A0_8133, I3 = 32'h0020_81B3;
    localparam logic [31:0] I4 = 32'h0031_0233, I5 = 32'h4041_82B3;
    localparam logic [31:0] A = 32'h0020_8463, B = 32'h0000_A503, C = 32'hDEAD_BEEF;
    localparam logic [31:0] D = 32'h1234_5678, E = 32'h00B5_0533, F = 32'h40B5_0533;
    localparam logic [31:0] G = 32'h0015_F593, H = 32'h00C1_2083, J = 32'hFE01_0113;
    localparam logic [31:0] K = 32'h8765_4321, L = 32'h0000_0297;

    if_de_payload_t q[$];
    if_de_payload_t e;
    int             pc_ctr;

    initial begin
        //              rst flsh iv inst pc   ordy  ov ir  exp_inst exp_pc
        tbl[0]  = mk(1, 0, 0, 0,  0,    1,    0, 0, NOP, 0);
        tbl[1]  = mk(0, 0, 1, I1, 32'h0, 1,   0, 1, NOP, 0);
        tbl[2]  = mk(0, 0, 1, I2, 32'h4, 1,   1, 1, I1, 32'h0);
        tbl[3]  = mk(0, 0, 1, I3, 32'h8, 1,   1, 1, I2, 32'h4);
        tbl[4]  = mk(0, 0, 1, I4, 32'hC, 0,   1, 1, I3, 32'h8);
        tbl[5]  = mk(0, 0, 1, I5, 32'h10, 0,  1, 0, I3, 32'h8);
        tbl[6]  = mk(0, 0, 1, I5, 32'h10, 0,  1, 0, I3, 32'h8);
        tbl[7]  = mk(0, 0, 1, I5, 32'h10, 0,  1, 0, I3, 32'h8);
        tbl[8]  = mk(0, 0, 1, I5, 32'h10, 1,  1, 0, I3, 32'h8);
        tbl[9]  = mk(0, 0, 1, I5, 32'h10, 1,  1, 1, I4, 32'hC);
        tbl[10] = mk(0, 0, 0, 0,  0,     1,   1, 1, I5, 32'h10);
        tbl[11] = mk(0, 0, 0, 0,  0,     1,   0, 1, NOP, 0);
        tbl[12] = mk(0, 0, 1, A,  32'h20, 0,  0, 1, NOP, 0);
        tbl[13] = mk(0, 0, 1, B,  32'h24, 0,  1, 1, A, 32'h20);
        tbl[14] = mk(0, 1, 1, C,  32'h28, 0,  1, 0, A, 32'h20);
        tbl[15] = mk(0, 0, 0, 0,  0,     1,   0, 1, NOP, 0);
        tbl[16] = mk(0, 1, 1, D,  32'h30, 0,  0, 1, NOP, 0);
        tbl[17] = mk(0, 0, 0, 0,  0,     1,   0, 1, NOP, 0);
        tbl[18] = mk(0, 0, 1, E,  32'h40, 0,  0, 1, NOP, 0);
        tbl[19] = mk(0, 0, 1, F,  32'h44, 0,  1, 1, E, 32'h40);
        tbl[20] = mk(0, 0, 1, G,  32'h48, 1,  1, 0, E, 32'h40);
        tbl[21] = mk(0, 0, 1, G,  32'h48, 1,  1, 1, F, 32'h44);
        tbl[22] = mk(0, 0, 0, 0,  0,     1,   1, 1, G, 32'h48);
        tbl[23] = mk(0, 0, 0, 0,  0,     1,   0, 1, NOP, 0);
        tbl[24] = mk(0, 0, 1, H,  32'h50, 0,  0, 1, NOP, 0);
        tbl[25] = mk(0, 0, 1, J,  32'h54, 0,  1, 1, H, 32'h50);
        tbl[26] = mk(1, 0, 1, K,  32'h58, 0,  1, 0, H, 32'h50);
        tbl[27] = mk(1, 0, 0, 0,  0,     1,   0, 0, NOP, 0);
        tbl[28] = mk(0, 0, 1, L,  32'h60, 1,  0, 1, NOP, 0);
        tbl[29] = mk(0, 0, 0, 0,  0,     1,   1, 1, L, 32'h60);
        tbl[30] = mk(0, 0, 0, 0,  0,     1,   0, 1, NOP, 0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        step(); step();

        for (int i = 0; i < 31; i++) begin
            rst       = tbl[i].rst;
            flush     = tbl[i].flush;
            in_valid  = tbl[i].in_valid;
            in_inst   = tbl[i].in_p.inst;
            in_pc     = tbl[i].in_p.pc;
            out_ready = tbl[i].out_ready;
            #1;
            chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
            chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(tbl[i].exp_ir));
            chk($sformatf("row%0d out_inst", i), 64'(out_inst), 64'(tbl[i].exp_p.inst));
            chk($sformatf("row%0d out_pc", i), 64'(out_pc), 64'(tbl[i].exp_p.pc));
            chk($sformatf("row%0d fields", i),
                64'({out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7}),
                64'(fields(tbl[i].exp_p.inst)));
            if (i == 3) begin
                // hand-decoded add x2,x1,x10
                chk("add_rs1", 64'(out_rs1), 64'd1);
                chk("add_rs2", 64'(out_rs2), 64'd10);
                chk("add_rd", 64'(out_rd), 64'd2);
                chk("add_opcode", 64'(out_opcode), 64'h33);
            end
            if (i == 15 || i == 27) begin
                chk($sformatf("row%0d bubble_rs", i), 64'({out_rs1, out_rs2, out_rd}), 64'd0);
                chk($sformatf("row%0d bubble_op", i), 64'(out_opcode), 64'h13);
            end
            step();
        end

        // Randomised handshake against a scoreboard queue.
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0;
        pc_ctr = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_inst   = $urandom;
            in_pc     = 32'(pc_ctr) << 2;
            #1;
            chk("rnd out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("rnd in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd spurious", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd inst", 64'(out_inst), 64'(e.inst));
                    chk("rnd pc", 64'(out_pc), 64'(e.pc));
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                e.inst = in_inst; e.pc = in_pc;
                q.push_back(e);
                pc_ctr++;
            end
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid && q.size() != 0) begin
                e = q.pop_front();
                chk("drain inst", 64'(out_inst), 64'(e.inst));
                chk("drain pc", 64'(out_pc), 64'(e.pc));
            end
            step();
        end
        chk("drain empty", 64'(q.size()), 64'd0);
        chk("drain out_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_de_pipe_reg.md
# if_de_pipe_reg

Parametrised, elastic IF→DE pipeline register for the RISC pipeline. It replaces the free-running fetch/decode latch with a valid/ready handshake, a one-entry skid buffer, stall back-pressure and a synchronous flush. It carries instruction and PC, and pre-extracts the register addresses and opcode fields for the decode stage. It sits between the fetch unit (instruction memory/PC) and decode/register-file read.

## Interface
Parameters:
- XLEN, 32: instruction and PC width. Must be ≥ 32; instruction fields use bits [31:0].
- REG_AW, 5: register address width.
- NOP_INST, 32'h0000_0013: bubble encoding (addi x0,x0,0), zero-extended to XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all held and incoming instructions (branch/jump redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  register can accept.
- in_inst  in  XLEN  fetched instruction.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  decode-side instruction valid.
- out_ready  in  1  decode accepts (low = stall).
- out_inst  out  XLEN  held instruction.
- out_pc  out  XLEN  held PC.
- out_rs1  out  REG_AW  inst[19:15].
- out_rs2  out  REG_AW  inst[24:20].
- out_rd  out  REG_AW  inst[11:7].
- out_opcode  out  7  inst[6:0].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].

## Operation
- Storage: main stage (drives all out_*) plus one skid entry. Each has a valid bit.
- Accept: in_fire = in_valid & in_ready. Drain: out_fire = out_valid & out_ready.
- in_ready = !skid_valid & !rst. It is driven from a register only; it has no combinational path from out_ready.
- Main load condition is `!main_valid | out_fire`. When it holds:
  - If skid_valid, main takes the skid entry and the skid empties.
  - Otherwise, if in_fire, main takes the input.
  - Otherwise main_valid goes to 0 and the payload is set to the bubble.
- Skid load: in_fire while main is valid and not draining writes the skid entry. The skid and the input never load main in the same cycle. When the skid empties into main and in_fire also occurs, the input goes into the skid.
- Bubble payload: out_inst = NOP_INST, out_pc = 0. All derived fields come from NOP_INST: rs1 = 0, rs2 = 0, rd = 0, opcode = 7'h13, funct3 = 0, funct7 = 0.
- Derived fields are registered together with out_inst and are always consistent with it.
- Flush has priority over everything except rst:
  - Both valids clear and main takes the bubble payload.
  - Any in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by decode.
- Instructions leave in the same order they were accepted. No duplication, no loss.

## Timing
- Reset: out_valid = 0, skid empty, out_inst = NOP_INST, out_pc = 0, out_rs1/rs2/rd = 0, out_opcode = 7'h13, out_funct3 = 0, out_funct7 = 0. in_ready = 0 while rst is high and 1 in the first cycle after.
- Reset during operation discards both entries the same way as flush.
- Latency: 1 cycle. An input accepted at edge N appears on out_* after edge N.
- Throughput: 1 instruction per cycle while out_ready = 1.
- Stall: the first out_ready-low cycle with an input arriving fills the skid. in_ready drops on the next cycle. At most 2 instructions are buffered.
- Release: the cycle after out_ready rises, main shows the skid entry. in_ready returns to 1 one cycle after the skid empties.
- Flush: out_valid = 0 and in_ready = 1 in the cycle after flush.
- Holding: out_* are stable while out_valid & !out_ready.

## Structure
- Shared package riscv_pipe_pkg holds:
  - the NOP_INST constant;
  - field bit-position localparams (RS1_LSB = 15, RS2_LSB = 20, RD_LSB = 7, FUNCT3_LSB = 12, FUNCT7_LSB = 25);
  - an if_de_payload_t struct {inst, pc}.
- One combinational sub-module, inst_field_split, maps inst to rs1/rs2/rd/opcode/funct3/funct7. It feeds the main-stage register input and will be reused by later stage registers.

## Test plan
- Reset, then stream 3 instructions with out_ready = 1: 0x00500093@pc 0x0, 0x00A08133@0x4, 0x002081B3@0x8.
  - Expect out_valid from the cycle after the first accept, 1 per cycle.
  - For 0x00A08133: rs1 = 1, rs2 = 10, rd = 2, opcode = 0x33.
- Stall with out_ready = 0 for 4 cycles while in_valid = 1.
  - Exactly 2 instructions are held and in_ready = 0 from the 2nd stall cycle.
  - On release, both emerge in order; out_* are stable throughout the stall.
- Flush while main and skid are full and in_valid = 1.
  - Next cycle: out_valid = 0, out_inst = 0x00000013, rs1/rs2/rd = 0, in_ready = 1.
  - No flushed PC ever appears on out_pc.
- Simultaneous skid drain and new input (skid full, out_ready rises, in_valid = 1).
  - Order is preserved: main, then skid entry, then new instruction, with no gaps.
- Assert rst mid-stream with both entries full.
  - All reset values appear next cycle and in_ready = 0 during rst.
  - Streaming resumes correctly after release.
- Random in_valid/out_ready for 10k cycles against a scoreboard queue: no loss, duplication or reorder.
